// File: rtl/day9_coord_parser_pkg.sv
// Shared types and constants for the day-9 coordinate stream parser.
// Coordinate width, ASCII codes, parser states and the coordinate pair record.
package day9_pkg;

  localparam int COORD_W = 17;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SP    = 8'h20;

  typedef enum logic [2:0] {S_X, S_Y, S_ERR, S_DONE} parse_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

endpackage

// File: rtl/day9_coord_parser_if.sv
// Byte-in / pair-out stream bundle between the byte source, the parser and the solver.
// master = source+consumer side (testbench or surrounding logic), slave = the parser.
interface day9_coord_if #(parameter int W = day9_pkg::COORD_W);
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [W-1:0] x_coord;
  logic [W-1:0] y_coord;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, x_coord, y_coord, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, x_coord, y_coord, out_valid, out_last
  );
endinterface

// File: rtl/day9_coord_parser_accum.sv
// Decimal accumulator: value = value*10 + digit, with overflow detection past 2^W-1.
// The register never takes an overflowing value, so the W+4 bit headroom is always enough.
module ascii_dec_accum import day9_pkg::*; #(
  parameter int W = COORD_W
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         digit_en,
  input  logic [3:0]   digit,
  output logic [W-1:0] value,
  output logic         overflow
);
  localparam int AW = W + 4;

  logic [AW-1:0] acc_q, acc_d, sum;

  always_comb begin
    sum      = (acc_q << 3) + (acc_q << 1) + AW'(digit);
    overflow = digit_en && (|sum[AW-1:W]);
    // value reflects the digit being accepted this cycle so a pair can close on it
    value    = digit_en ? sum[W-1:0] : acc_q[W-1:0];
    acc_d    = acc_q;
    if (clear)                      acc_d = '0;
    else if (digit_en && !overflow) acc_d = sum;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end
endmodule

// File: rtl/day9_coord_parser.sv
// Parses an ASCII "x,y\n" byte stream into coordinate pairs with valid/ready handshakes.
// Holds the line FSM, the one-deep output register and the emitted-pair counter.
module day9_coord_parser import day9_pkg::*; #(
  parameter int W     = COORD_W,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  day9_coord_if.slave      bus,
  output logic [CNT_W-1:0] pair_count,
  output logic             done,
  output logic             error
);
  parse_state_t     state_q, state_d;
  logic             x_seen_q, x_seen_d, y_seen_q, y_seen_d;
  logic             armed_q, armed_d;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [W-1:0]     x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic         accept, is_digit, is_blank, load, clr, x_en, y_en, x_ovf, y_ovf;
  logic [W-1:0] x_val, y_val;

  ascii_dec_accum #(.W(W)) u_x_acc (
    .clock, .reset_n, .clear(clr), .digit_en(x_en), .digit(bus.in_data[3:0]),
    .value(x_val), .overflow(x_ovf)
  );

  ascii_dec_accum #(.W(W)) u_y_acc (
    .clock, .reset_n, .clear(clr), .digit_en(y_en), .digit(bus.in_data[3:0]),
    .value(y_val), .overflow(y_ovf)
  );

  // armed_q keeps in_ready low through reset and the first edge after release
  assign bus.in_ready  = armed_q && (state_q == S_X || state_q == S_Y) &&
                         !(out_valid_q && !bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign is_digit      = (bus.in_data >= CH_0) && (bus.in_data <= CH_9);
  assign is_blank      = (bus.in_data == CH_CR) || (bus.in_data == CH_SP);

  assign bus.x_coord   = x_q;
  assign bus.y_coord   = y_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign pair_count    = cnt_q;
  assign done          = (state_q == S_DONE);
  assign error         = (state_q == S_ERR);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d  = state_q;
    x_seen_d = x_seen_q;
    y_seen_d = y_seen_q;
    armed_d  = 1'b1;
    x_en     = 1'b0;
    y_en     = 1'b0;
    clr      = 1'b0;
    load     = 1'b0;

    if (accept) begin
      case (state_q)
        S_X: begin
          if (is_digit) begin
            x_en     = 1'b1;
            x_seen_d = 1'b1;
          end else if (bus.in_data == CH_COMMA) begin
            state_d = x_seen_q ? S_Y : S_ERR;
          end else if (!is_blank && bus.in_data != CH_LF) begin
            state_d = S_ERR;
          end
        end
        S_Y: begin
          if (is_digit) begin
            y_en     = 1'b1;
            y_seen_d = 1'b1;
            load     = bus.in_last;
          end else if (bus.in_data == CH_LF && y_seen_q) begin
            load = 1'b1;
          end else if (!is_blank) begin
            state_d = S_ERR;
          end
        end
        default: ;
      endcase

      if ((x_en && x_ovf) || (y_en && y_ovf)) begin
        state_d = S_ERR;
        load    = 1'b0;
      end

      if (load) begin
        clr      = 1'b1;
        x_seen_d = 1'b0;
        y_seen_d = 1'b0;
        state_d  = S_X;
      end

      // a final byte that leaves a half-built line is malformed input
      if (bus.in_last && state_d != S_ERR)
        state_d = (!load && (state_d == S_Y || x_seen_d)) ? S_ERR : S_DONE;
    end

    out_valid_d = load || (out_valid_q && !bus.out_ready);
    out_last_d  = load ? bus.in_last : out_last_q;
    x_d         = load ? x_val : x_q;
    y_d         = load ? y_val : y_q;
    cnt_d       = (load && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_X;
      x_seen_q    <= 1'b0;
      y_seen_q    <= 1'b0;
      armed_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      x_seen_q    <= x_seen_d;
      y_seen_q    <= y_seen_d;
      armed_q     <= armed_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: tb/tb_day9_coord_parser.sv
// Directed bench for day9_coord_parser: a table of streams with hand-computed pairs,
// plus hand-written sequences for output back-pressure and reset mid-line.
module tb_day9_coord_parser;
  import day9_pkg::*;

  localparam int W     = COORD_W;
  localparam int CNT_W = 16;

  logic             clock;
  logic             reset_n;
  logic [CNT_W-1:0] pair_count;
  logic             done;
  logic             error;

  day9_coord_if #(.W(W)) bus ();

  day9_coord_parser #(.W(W), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .pair_count (pair_count),
    .done       (done),
    .error      (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  coord_t got_pair[$];
  bit     got_last[$];

  // one record per transfer: the pair is taken on the posedge after this negedge
  always @(negedge clock) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      got_pair.push_back('{x: bus.x_coord, y: bus.y_coord});
      got_last.push_back(bus.out_last);
    end
  end

  typedef struct {
    string text;
    bit    last;
    int    n;
    int    ex[3];
    int    ey[3];
    bit    el[3];
    bit    err;
    bit    dn;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input string t, input bit l, input int n,
                         input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2, input bit [2:0] lm,
                         input bit e, input bit d);
    vecs[i].text = t;
    vecs[i].last = l;
    vecs[i].n    = n;
    vecs[i].ex   = '{x0, x1, x2};
    vecs[i].ey   = '{y0, y1, y2};
    vecs[i].el   = '{lm[0], lm[1], lm[2]};
    vecs[i].err  = e;
    vecs[i].dn   = d;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = 8'h00;
    reset_n       = 1'b0;
    #1;
    check("reset_outputs",
          {24'd0, bus.in_ready, bus.out_valid, bus.out_last, done, error,
           |bus.x_coord, |bus.y_coord, |pair_count}, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    got_pair.delete();
    got_last.delete();
    @(posedge clock);
    #1;
  endtask

  // drives one byte until accepted; gives up quietly once the parser is in error/done
  task automatic send_byte(input logic [7:0] b, input bit last, output bit stop);
    bit accepted = 1'b0;
    stop         = 1'b0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    for (int c = 0; c < 200 && !accepted && !stop; c++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        @(posedge clock);
        #1;
        accepted = 1'b1;
      end else if (error || done) begin
        stop = 1'b1;
      end else begin
        @(posedge clock);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!accepted && !stop) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: byte %0d not accepted within 200 cycles", b);
      stop = 1'b1;
    end
  endtask

  task automatic send_str(input string s, input bit last);
    bit stop;
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], last && (i == s.len() - 1), stop);
      if (stop) break;
    end
  endtask

  task automatic check_pairs(input string tag, input int n, input int ex[3],
                             input int ey[3], input bit el[3]);
    check({tag, "_npairs"}, got_pair.size(), n);
    for (int k = 0; k < n && k < got_pair.size(); k++) begin
      check($sformatf("%s_x%0d", tag, k), 32'(got_pair[k].x), ex[k]);
      check($sformatf("%s_y%0d", tag, k), 32'(got_pair[k].y), ey[k]);
      check($sformatf("%s_last%0d", tag, k), 32'(got_last[k]), 32'(el[k]));
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;

    set_vec(0, "7,1\n11,1\n11,7\n",        0, 3, 7, 1, 11, 1, 11, 7, 3'b000, 0, 0);
    set_vec(1, "131071,0\n131072,5\n",     0, 1, 131071, 0, 0, 0, 0, 0, 3'b000, 1, 0);
    set_vec(2, "3,4\015\n\n5,6",           1, 2, 3, 4, 5, 6, 0, 0, 3'b010, 0, 1);
    set_vec(3, "12a,3\n",                  0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0);
    set_vec(4, ",5\n",                     0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0);
    set_vec(5, "0,131071\n",               1, 1, 0, 131071, 0, 0, 0, 0, 3'b001, 0, 1);
    set_vec(6, "4,",                       1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0);
    set_vec(7, " \n\015",                  1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1);
    set_vec(8, "1,\n",                     0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0);
    set_vec(9, "5,9 \n",                   0, 1, 5, 9, 0, 0, 0, 0, 3'b000, 0, 0);

    for (int v = 0; v < 10; v++) begin
      string tag;
      tag = $sformatf("v%0d", v);
      do_reset();
      send_str(vecs[v].text, vecs[v].last);
      repeat (4) @(negedge clock);
      check_pairs(tag, vecs[v].n, vecs[v].ex, vecs[v].ey, vecs[v].el);
      check({tag, "_error"},      32'(error),         32'(vecs[v].err));
      check({tag, "_done"},       32'(done),          32'(vecs[v].dn));
      check({tag, "_pair_count"}, 32'(pair_count),    32'(vecs[v].n));
      check({tag, "_in_ready"},   32'(bus.in_ready),  32'(!(vecs[v].err || vecs[v].dn)));
      check({tag, "_out_valid"},  32'(bus.out_valid), 32'd0);
    end

    // back-pressure: first pair held for 5 cycles, nothing accepted, nothing lost
    do_reset();
    bus.out_ready = 1'b0;
    fork
      send_str("7,1\n11,1\n11,7\n", 1'b0);
      begin
        bit seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
          @(negedge clock);
          seen = bus.out_valid;
        end
        if (!seen) begin
          checks++;
          errors++;
          $display("FAIL stall_wait: out_valid not seen within 100 cycles");
        end
        for (int c = 0; c < 5; c++) begin
          check($sformatf("stall_in_ready%0d", c), 32'(bus.in_ready), 32'd0);
          check($sformatf("stall_hold%0d", c),
                {bus.out_valid, 7'd0, 7'd0, bus.x_coord[16:0]}, {1'b1, 14'd0, 17'd7});
          check($sformatf("stall_y%0d", c), 32'(bus.y_coord), 32'd1);
          @(negedge clock);
        end
        @(posedge clock);
        #1 bus.out_ready = 1'b1;
      end
    join
    repeat (4) @(negedge clock);
    check_pairs("stall", 3, '{7, 11, 11}, '{1, 1, 7}, '{0, 0, 0});
    check("stall_pair_count", 32'(pair_count), 32'd3);
    check("stall_error", 32'(error), 32'd0);

    // reset in the middle of a line discards the partial pair
    do_reset();
    send_str("999,8", 1'b0);
    @(negedge clock);
    do_reset();
    send_str("1,2\n", 1'b0);
    repeat (4) @(negedge clock);
    check_pairs("midrst", 1, '{1, 0, 0}, '{2, 0, 0}, '{0, 0, 0});
    check("midrst_pair_count", 32'(pair_count), 32'd1);
    check("midrst_error", 32'(error), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
